// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS-subset control path:
// opcodes, funct codes, state encodings, mux-select codes and the control word.
package multicycle_control_pkg;

  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_EXEC_R  = 4'd2;
  localparam logic [3:0] ST_EXEC_I  = 4'd3;
  localparam logic [3:0] ST_EXEC_BR = 4'd4;
  localparam logic [3:0] ST_JUMP    = 4'd5;
  localparam logic [3:0] ST_JUMP_R  = 4'd6;
  localparam logic [3:0] ST_JAL_WB  = 4'd7;
  localparam logic [3:0] ST_MEM_RD  = 4'd8;
  localparam logic [3:0] ST_MEM_WR  = 4'd9;
  localparam logic [3:0] ST_WB_R    = 4'd10;
  localparam logic [3:0] ST_WB_I    = 4'd11;
  localparam logic [3:0] ST_WB_MEM  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [1:0] PC_SRC_SEQ   = 2'd0;
  localparam logic [1:0] PC_SRC_BT    = 2'd1;
  localparam logic [1:0] PC_SRC_JADDR = 2'd2;
  localparam logic [1:0] PC_SRC_RS    = 2'd3;

  localparam logic [1:0] REG_DST_RT  = 2'd0;
  localparam logic [1:0] REG_DST_RD  = 2'd1;
  localparam logic [1:0] REG_DST_R31 = 2'd2;

  localparam logic [1:0] REG_SRC_ALU = 2'd0;
  localparam logic [1:0] REG_SRC_MDR = 2'd1;
  localparam logic [1:0] REG_SRC_PC  = 2'd2;

  localparam logic [1:0] ALU_B_RT   = 2'd0;
  localparam logic [1:0] ALU_B_FOUR = 2'd1;
  localparam logic [1:0] ALU_B_SIMM = 2'd2;
  localparam logic [1:0] ALU_B_ZIMM = 2'd3;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] reg_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       bt_we;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Successor of DECODE; FETCH doubles as the "unsupported instruction" marker.
  function automatic logic [3:0] decode_next(input logic [5:0] opcode, input logic [5:0] funct);
    logic [3:0] nxt;
    nxt = ST_FETCH;
    case (opcode)
      OP_LW, OP_SW, OP_ADDI, OP_XORI: nxt = ST_EXEC_I;
      OP_BNE:                         nxt = ST_EXEC_BR;
      OP_J:                           nxt = ST_JUMP;
      OP_JAL:                         nxt = ST_JAL_WB;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_SLT: nxt = ST_EXEC_R;
          FN_JR:                  nxt = ST_JUMP_R;
          default:                nxt = ST_FETCH;
        endcase
      end
      default:                        nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle: decoded instruction fields, ALU flag and memory
// handshake in, every datapath enable and select out.
interface multicycle_control_if;
  import multicycle_control_pkg::*;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       ir_we;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       reg_we;
  logic [1:0] reg_dst;
  logic [1:0] reg_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       bt_we;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, pc_src, ir_we, mem_req, mem_we, mem_addr_sel, reg_we, reg_dst,
           reg_src, alu_src_a, alu_src_b, alu_op, bt_we, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, pc_src, ir_we, mem_req, mem_we, mem_addr_sel, reg_we, reg_dst,
           reg_src, alu_src_a, alu_src_b, alu_op, bt_we, illegal, state
  );
endinterface

// File: rtl/multicycle_control_alu_op_decode.sv
// R-type funct to ALU operation map; unsupported functs fall back to ADD
// (they never reach EXEC_R because DECODE flags them illegal).
module alu_op_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op
);
  always_comb begin
    alu_op = ALU_ADD;
    case (funct)
      FN_SUB:  alu_op = ALU_SUB;
      FN_SLT:  alu_op = ALU_SLT;
      default: alu_op = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/
// writeback and stalls FETCH, MEM_RD and MEM_WR until mem_ready.
//
// state       | meaning
// FETCH   (0) | read instruction at PC, PC <= PC+4 when mem_ready
// DECODE  (1) | branch target capture, dispatch on opcode/funct
// EXEC_R  (2) | R-type ALU op Rs,Rt
// EXEC_I  (3) | Rs + imm (address or ADDI) / Rs ^ zimm (XORI)
// EXEC_BR (4) | BNE compare, PC <= target when not equal
// JUMP    (5) | PC <= jump address
// JUMP_R  (6) | PC <= Rs
// JAL_WB  (7) | r31 <= PC+4, PC <= jump address
// MEM_RD  (8) | load, wait for mem_ready
// MEM_WR  (9) | store, wait for mem_ready
// WB_R   (10) | Rd <= ALU result
// WB_I   (11) | Rt <= ALU result
// WB_MEM (12) | Rt <= memory data
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = ST_FETCH
) (
  input logic                  clk,
  input logic                  reset_n,
  multicycle_control_if.master bus
);

  logic [3:0] state_q, state_d;
  logic [2:0] funct_alu_op;
  ctrl_t      ctrl;

  alu_op_decode u_alu_op_decode (
    .funct  (bus.funct),
    .alu_op (funct_alu_op)
  );

  always_comb begin
    ctrl    = CTRL_IDLE;
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = ALU_B_FOUR;
        if (bus.mem_ready) begin
          ctrl.ir_we = 1'b1;
          ctrl.pc_we = 1'b1;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ctrl.alu_src_b = ALU_B_SIMM;
        ctrl.bt_we     = 1'b1;
        state_d        = decode_next(bus.opcode, bus.funct);
        ctrl.illegal   = (state_d == ST_FETCH);
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_RT;
        ctrl.alu_op    = funct_alu_op;
        state_d        = ST_WB_R;
      end
      ST_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        if (bus.opcode == OP_XORI) begin
          ctrl.alu_src_b = ALU_B_ZIMM;
          ctrl.alu_op    = ALU_XOR;
        end else begin
          ctrl.alu_src_b = ALU_B_SIMM;
        end
        if (bus.opcode == OP_LW)      state_d = ST_MEM_RD;
        else if (bus.opcode == OP_SW) state_d = ST_MEM_WR;
        else                          state_d = ST_WB_I;
      end
      ST_EXEC_BR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_SRC_BT;
        ctrl.pc_we     = ~bus.zero;
        state_d        = ST_FETCH;
      end
      ST_JUMP: begin
        ctrl.pc_src = PC_SRC_JADDR;
        ctrl.pc_we  = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_JUMP_R: begin
        ctrl.pc_src = PC_SRC_RS;
        ctrl.pc_we  = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_JAL_WB: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = REG_DST_R31;
        ctrl.reg_src = REG_SRC_PC;
        ctrl.pc_src  = PC_SRC_JADDR;
        ctrl.pc_we   = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_MEM_RD: begin
        ctrl.mem_req      = 1'b1;
        ctrl.mem_addr_sel = 1'b1;
        if (bus.mem_ready) state_d = ST_WB_MEM;
      end
      ST_MEM_WR: begin
        ctrl.mem_req      = 1'b1;
        ctrl.mem_we       = 1'b1;
        ctrl.mem_addr_sel = 1'b1;
        if (bus.mem_ready) state_d = ST_FETCH;
      end
      ST_WB_R: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = REG_DST_RD;
        ctrl.reg_src = REG_SRC_ALU;
        state_d      = ST_FETCH;
      end
      ST_WB_I: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = REG_DST_RT;
        ctrl.reg_src = REG_SRC_ALU;
        state_d      = ST_FETCH;
      end
      ST_WB_MEM: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = REG_DST_RT;
        ctrl.reg_src = REG_SRC_MDR;
        state_d      = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    // Reset is synchronous, so the datapath must be quiesced combinationally
    // while reset_n is held low, whatever state the flop still holds.
    if (!reset_n) ctrl = CTRL_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= RESET_STATE;
    else          state_q <= state_d;
  end

  assign bus.pc_we        = ctrl.pc_we;
  assign bus.pc_src       = ctrl.pc_src;
  assign bus.ir_we        = ctrl.ir_we;
  assign bus.mem_req      = ctrl.mem_req;
  assign bus.mem_we       = ctrl.mem_we;
  assign bus.mem_addr_sel = ctrl.mem_addr_sel;
  assign bus.reg_we       = ctrl.reg_we;
  assign bus.reg_dst      = ctrl.reg_dst;
  assign bus.reg_src      = ctrl.reg_src;
  assign bus.alu_src_a    = ctrl.alu_src_a;
  assign bus.alu_src_b    = ctrl.alu_src_b;
  assign bus.alu_op       = ctrl.alu_op;
  assign bus.bt_we        = ctrl.bt_we;
  assign bus.illegal      = ctrl.illegal;
  assign bus.state        = state_q;

endmodule
